// File: rtl/circle_raster_engine_if.sv
// Pixel stream port of circle_raster_engine: valid/ready handshake carrying one
// clipped pixel (x, y, colour) per transfer.
interface circle_raster_engine_if #(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int COLW = 3
) ();
  logic            px_valid;
  logic            px_ready;
  logic [XW-1:0]   px_x;
  logic [YW-1:0]   px_y;
  logic [COLW-1:0] px_colour;

  modport master (output px_valid, output px_x, output px_y, output px_colour, input px_ready);
  modport slave  (input px_valid, input px_x, input px_y, input px_colour, output px_ready);
endinterface

// File: rtl/circle_raster_engine.sv
// Midpoint circle rasteriser: walks one octant and streams 8-way mirrored, screen-clipped pixels.
// Defining CIRCLE_FILL_EN switches the emitter to four horizontal spans per step (filled disc).
module circle_raster_engine #(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int RW    = 6,
  parameter int COLW  = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XW-1:0]   cx,
  input  logic [YW-1:0]   cy,
  input  logic [RW-1:0]   radius,
  input  logic [COLW-1:0] colour_in,
  output logic            busy,
  output logic            done,
  circle_raster_engine_if.master px
);

  localparam int MW = (XW > YW) ? XW : YW;
  localparam int CW = ((MW > RW) ? MW : RW) + 2;
  localparam int DW = RW + 3;
`ifdef CIRCLE_FILL_EN
  localparam int OW = 2;
`else
  localparam int OW = 3;
`endif

  localparam logic [OW-1:0]        OCT_LAST = {OW{1'b1}};
  localparam logic [OW-1:0]        OCT_ONE  = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [RW:0]          ONE_W    = {{RW{1'b0}}, 1'b1};
  localparam logic signed [DW-1:0] D_THREE  = {{(DW-2){1'b0}}, 2'd3};
  localparam logic signed [DW-1:0] D_NEG    = {{(DW-3){1'b0}}, 3'd6};
  localparam logic signed [DW-1:0] D_POS    = {{(DW-4){1'b0}}, 4'd10};
  localparam logic signed [CW-1:0] XMAX_S   = CW'(X_MAX);
  localparam logic signed [CW-1:0] YMAX_S   = CW'(Y_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    EMIT = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [XW-1:0]         cx_r, cx_s;
  logic [YW-1:0]         cy_r, cy_s;
  logic [RW-1:0]         rad_r, rad_s;
  logic [COLW-1:0]       col_r, col_s;
  logic [RW-1:0]         x_r, x_s, y_r, y_s;
  logic signed [DW-1:0]  d_r, d_s;
  logic [OW-1:0]         oct_r, oct_s;
  logic                  vld_r, busy_r, done_r;
  logic [XW-1:0]         px_x_r;
  logic [YW-1:0]         px_y_r;

  logic                  adv_s, cont_s, vis_s;
  logic [RW:0]           xn_w_s, yn_w_s;
  logic signed [RW:0]    diff_s;
  logic signed [DW-1:0]  d4x_s, d4xy_s;
  logic signed [CW-1:0]  pt_x_s, pt_y_s;
`ifdef CIRCLE_FILL_EN
  logic [RW:0]           pos_r, pos_s, span_end_s;
`endif

  // next-state, octant/span walk and midpoint error update
  always_comb begin
    state_s = state_r;
    cx_s    = cx_r;
    cy_s    = cy_r;
    rad_s   = rad_r;
    col_s   = col_r;
    x_s     = x_r;
    y_s     = y_r;
    d_s     = d_r;
    oct_s   = oct_r;
`ifdef CIRCLE_FILL_EN
    pos_s      = pos_r;
    span_end_s = {(oct_r[1] ? y_r : x_r), 1'b0};
`endif
    // an off-screen point is held with px_valid low and retires after one cycle
    adv_s   = vld_r ? px.px_ready : 1'b1;
    d4x_s   = $signed({1'b0, x_r, 2'b00});
    diff_s  = $signed({1'b0, x_r}) - $signed({1'b0, y_r});
    d4xy_s  = $signed({diff_s, 2'b00});
    xn_w_s  = {1'b0, x_r} + ONE_W;
    yn_w_s  = d_r[DW-1] ? {1'b0, y_r} : ({1'b0, y_r} - ONE_W);
    // y can wrap below zero (radius 0): the extra top bit terminates the walk
    cont_s  = !yn_w_s[RW] && (xn_w_s <= yn_w_s);
    case (state_r)
      IDLE: begin
        if (start) begin
          cx_s    = cx;
          cy_s    = cy;
          rad_s   = radius;
          col_s   = colour_in;
          state_s = INIT;
        end else begin
          state_s = IDLE;
        end
      end
      INIT: begin
        x_s     = {RW{1'b0}};
        y_s     = rad_r;
        d_s     = D_THREE - $signed({2'b00, rad_r, 1'b0});
        oct_s   = {OW{1'b0}};
`ifdef CIRCLE_FILL_EN
        pos_s   = {(RW+1){1'b0}};
`endif
        state_s = EMIT;
      end
      EMIT: begin
        if (adv_s) begin
`ifdef CIRCLE_FILL_EN
          if (pos_r == span_end_s) begin
            pos_s = {(RW+1){1'b0}};
            if (oct_r == OCT_LAST) begin
              oct_s   = {OW{1'b0}};
              state_s = STEP;
            end else begin
              oct_s = oct_r + OCT_ONE;
            end
          end else begin
            pos_s = pos_r + ONE_W;
          end
`else
          if (oct_r == OCT_LAST) begin
            oct_s   = {OW{1'b0}};
            state_s = STEP;
          end else begin
            oct_s = oct_r + OCT_ONE;
          end
`endif
        end else begin
          state_s = EMIT;
        end
      end
      STEP: begin
        x_s     = xn_w_s[RW-1:0];
        y_s     = yn_w_s[RW-1:0];
        d_s     = d_r[DW-1] ? (d_r + d4x_s + D_NEG) : (d_r + d4xy_s + D_POS);
        state_s = cont_s ? EMIT : DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // candidate pixel for the point the walk is about to present, plus clip test
  always_comb begin
    logic signed [CW-1:0] xo, yo, cxo, cyo;
    xo  = $signed({{(CW-RW){1'b0}}, x_s});
    yo  = $signed({{(CW-RW){1'b0}}, y_s});
    cxo = $signed({{(CW-XW){1'b0}}, cx_r});
    cyo = $signed({{(CW-YW){1'b0}}, cy_r});
`ifdef CIRCLE_FILL_EN
    begin
      logic signed [CW-1:0] half, roff, poso;
      half   = oct_s[1] ? yo : xo;
      roff   = oct_s[1] ? xo : yo;
      poso   = $signed({{(CW-RW-1){1'b0}}, pos_s});
      pt_x_s = cxo - half + poso;
      pt_y_s = oct_s[0] ? (cyo - roff) : (cyo + roff);
    end
`else
    case (oct_s)
      3'd0:    begin pt_x_s = cxo + xo; pt_y_s = cyo + yo; end
      3'd1:    begin pt_x_s = cxo - xo; pt_y_s = cyo + yo; end
      3'd2:    begin pt_x_s = cxo + xo; pt_y_s = cyo - yo; end
      3'd3:    begin pt_x_s = cxo - xo; pt_y_s = cyo - yo; end
      3'd4:    begin pt_x_s = cxo + yo; pt_y_s = cyo + xo; end
      3'd5:    begin pt_x_s = cxo - yo; pt_y_s = cyo + xo; end
      3'd6:    begin pt_x_s = cxo + yo; pt_y_s = cyo - xo; end
      3'd7:    begin pt_x_s = cxo - yo; pt_y_s = cyo - xo; end
      default: begin pt_x_s = cxo;      pt_y_s = cyo;      end
    endcase
`endif
    vis_s = !pt_x_s[CW-1] && (pt_x_s <= XMAX_S) && !pt_y_s[CW-1] && (pt_y_s <= YMAX_S);
  end

  // state and walk registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cx_r    <= {XW{1'b0}};
      cy_r    <= {YW{1'b0}};
      rad_r   <= {RW{1'b0}};
      col_r   <= {COLW{1'b0}};
      x_r     <= {RW{1'b0}};
      y_r     <= {RW{1'b0}};
      d_r     <= {DW{1'b0}};
      oct_r   <= {OW{1'b0}};
`ifdef CIRCLE_FILL_EN
      pos_r   <= {(RW+1){1'b0}};
`endif
    end else begin
      state_r <= state_s;
      cx_r    <= cx_s;
      cy_r    <= cy_s;
      rad_r   <= rad_s;
      col_r   <= col_s;
      x_r     <= x_s;
      y_r     <= y_s;
      d_r     <= d_s;
      oct_r   <= oct_s;
`ifdef CIRCLE_FILL_EN
      pos_r   <= pos_s;
`endif
    end
  end

  // registered output stage; pixel data only reloads when a visible point is presented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      px_x_r <= {XW{1'b0}};
      px_y_r <= {YW{1'b0}};
    end else begin
      vld_r  <= (state_s == EMIT) && vis_s;
      busy_r <= (state_s == INIT) || (state_s == EMIT) || (state_s == STEP);
      done_r <= (state_s == DONE);
      if ((state_s == EMIT) && vis_s) begin
        px_x_r <= pt_x_s[XW-1:0];
        px_y_r <= pt_y_s[YW-1:0];
      end else begin
        px_x_r <= px_x_r;
        px_y_r <= px_y_r;
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign px.px_valid  = vld_r;
  assign px.px_x      = px_x_r;
  assign px.px_y      = px_y_r;
  assign px.px_colour = col_r;

endmodule

// File: tb/tb_circle_raster_engine.sv
// Self-checking bench for circle_raster_engine: table of circles with hand-computed counts,
// a software midpoint model for the full pixel order, plus backpressure/start/reset sequences.
module tb_circle_raster_engine;
  localparam int XW = 8, YW = 7, RW = 6, COLW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic [RW-1:0]   radius;
  logic [COLW-1:0] colour_in;
  logic            busy, done;

  circle_raster_engine_if #(.XW(XW), .YW(YW), .COLW(COLW)) pif ();

  circle_raster_engine #(.XW(XW), .YW(YW), .RW(RW), .COLW(COLW), .X_MAX(159), .Y_MAX(119)) dut (
    .clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy), .radius(radius),
    .colour_in(colour_in), .busy(busy), .done(done), .px(pif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cx; int cy; int r; int col; int mode; int spam;
    int exp_cnt; int exp_fx; int exp_fy;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int exp_x[$];
  int exp_y[$];
  int first_vis;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void add_pt(input int px, input int py);
    bit vis;
    vis = (px >= 0) && (px <= 159) && (py >= 0) && (py <= 119);
    if (first_vis < 0) first_vis = vis ? 1 : 0;
    if (vis) begin
      exp_x.push_back(px);
      exp_y.push_back(py);
    end
  endfunction

  task automatic build_model(input int mcx, input int mcy, input int mr);
    int x, y, d;
    exp_x.delete();
    exp_y.delete();
    first_vis = -1;
    x = 0; y = mr; d = 3 - 2 * mr;
    while (x <= y) begin
`ifdef CIRCLE_FILL_EN
      for (int s = 0; s < 4; s++) begin
        int h, ro, row;
        h   = (s < 2) ? x : y;
        ro  = (s < 2) ? y : x;
        row = (s % 2 == 0) ? mcy + ro : mcy - ro;
        for (int p = mcx - h; p <= mcx + h; p++) add_pt(p, row);
      end
`else
      add_pt(mcx + x, mcy + y); add_pt(mcx - x, mcy + y);
      add_pt(mcx + x, mcy - y); add_pt(mcx - x, mcy - y);
      add_pt(mcx + y, mcy + x); add_pt(mcx - y, mcy + x);
      add_pt(mcx + y, mcy - x); add_pt(mcx - y, mcy - x);
`endif
      if (d < 0) d = d + 4 * x + 6;
      else begin
        d = d + 4 * (x - y) + 10;
        y = y - 1;
      end
      x = x + 1;
    end
  endtask

  task automatic run_circle(input vec_t v, output int npix, output int fx, output int fy);
    int  gx[$];
    int  gy[$];
    int  cyc, first_cyc, hx, hy;
    bit  seen_done, prev_stall, rdy;
    build_model(v.cx, v.cy, v.r);
    @(negedge clk);
    cx = XW'(v.cx); cy = YW'(v.cy); radius = RW'(v.r); colour_in = COLW'(v.col);
    start = 1'b1;
    pif.px_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; first_cyc = -1; seen_done = 1'b0; prev_stall = 1'b0; hx = 0; hy = 0;
    check("busy_after_start", int'(busy), 1);
    while (!seen_done && cyc < 3000) begin
      if (v.spam != 0 && cyc >= 3 && cyc <= 6) begin
        start = 1'b1; cx = 8'd10; cy = 7'd10; radius = 6'd9;
      end else begin
        start = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", int'(pif.px_valid), 1);
        check("stall_x", int'(pif.px_x), hx);
        check("stall_y", int'(pif.px_y), hy);
      end
      if (pif.px_valid && first_cyc < 0) first_cyc = cyc;
      if (done) begin
        seen_done = 1'b1;
      end else begin
        case (v.mode)
          1:       rdy = !(cyc >= 6 && cyc < 16);
          2:       rdy = (cyc % 3) != 1;
          default: rdy = 1'b1;
        endcase
        pif.px_ready = rdy;
        if (pif.px_valid && rdy) begin
          gx.push_back(int'(pif.px_x));
          gy.push_back(int'(pif.px_y));
          check("colour", int'(pif.px_colour), v.col);
        end
        prev_stall = pif.px_valid && !rdy;
        hx = int'(pif.px_x);
        hy = int'(pif.px_y);
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("valid_at_done", int'(pif.px_valid), 0);
    check("busy_at_done", int'(busy), 0);
    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_single_pulse", int'(done), 0);
    check("start_in_done_ignored", int'(busy), 0);
    check("pix_count", gx.size(), exp_x.size());
    for (int i = 0; i < gx.size() && i < exp_x.size(); i++)
      check("pix_seq", gx[i] * 1000 + gy[i], exp_x[i] * 1000 + exp_y[i]);
    if (first_vis == 1) check("first_latency", first_cyc, 2);
    npix = gx.size();
    fx = (gx.size() > 0) ? gx[0] : -1;
    fy = (gy.size() > 0) ? gy[0] : -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n, fx, fy;
    vecs[0] = '{80,  60,  0, 5, 0, 0,  8,  80,  60};
    vecs[1] = '{80,  60,  3, 2, 0, 0, 24,  80,  63};
    vecs[2] = '{2,   2,   5, 7, 0, 0, 14,   2,   7};
    vecs[3] = '{80,  60,  3, 3, 1, 0, 24,  80,  63};
    vecs[4] = '{80,  60,  3, 1, 0, 1, 24,  80,  63};
    vecs[5] = '{158, 118, 2, 6, 2, 0,  8, 158, 116};

    start = 1'b0; cx = 8'd0; cy = 7'd0; radius = 6'd0; colour_in = 3'd0;
    pif.px_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(pif.px_valid), 0);
    check("rst_x", int'(pif.px_x), 0);
    check("rst_y", int'(pif.px_y), 0);
    check("rst_colour", int'(pif.px_colour), 0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_circle(vecs[i], n, fx, fy);
`ifndef CIRCLE_FILL_EN
      check("tbl_count", n, vecs[i].exp_cnt);
      check("tbl_first_x", fx, vecs[i].exp_fx);
      check("tbl_first_y", fy, vecs[i].exp_fy);
`endif
    end

    // abandon a circle mid-stream with an asynchronous reset
    @(negedge clk);
    cx = 8'd80; cy = 7'd60; radius = 6'd10; colour_in = 3'd4;
    start = 1'b1;
    pif.px_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", int'(pif.px_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_x", int'(pif.px_x), 0);
    check("midrst_y", int'(pif.px_y), 0);
    check("midrst_colour", int'(pif.px_colour), 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end
    rst = 1'b1;
    run_circle(vecs[1], n, fx, fy);
`ifndef CIRCLE_FILL_EN
    check("post_rst_count", n, 24);
    check("post_rst_first_y", fy, 63);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
